serial_mult_responder: RTL and testbench



---
 rtl/mult_pkg.sv | 21 ++
 rtl/if_axi_stream.sv | 20 ++
 rtl/limb_mac.sv | 30 +++
 rtl/serial_mult_responder.sv | 115 +++++++++++
 tb/tb_serial_mult_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the serial multiplier responder.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } mult_state_t;

    // Number of LIMB_BITS-wide steps needed to cover a DAT_BITS operand.
    function automatic int unsigned num_limb(input int unsigned dat_bits,
                                             input int unsigned limb_bits);
        return (dat_bits + limb_bits - 1) / limb_bits;
    endfunction

    // Width of a counter indexing n limbs (at least one bit).
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Single-beat streaming bus with valid/ready handshake, framing and tag.
interface if_axi_stream #(
    parameter int unsigned DAT_BITS = 8,
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned MOD_BITS = 8
);

    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport source (output val, sop, eop, err, mod, dat, ctl, input rdy);
    modport sink   (input val, sop, eop, err, mod, dat, ctl, output rdy);

endinterface

// File: rtl/limb_mac.sv
// One serial step: acc + (a_limb * b) placed at the weight of limb i_idx.
module limb_mac
    import mult_pkg::*;
#(
    parameter int unsigned DAT_BITS  = 381,
    parameter int unsigned LIMB_BITS = 64,
    localparam int unsigned NUM_LIMB = num_limb(DAT_BITS, LIMB_BITS),
    localparam int unsigned IDX_BITS = cnt_bits(NUM_LIMB),
    localparam int unsigned ACC_BITS = 2 * DAT_BITS + LIMB_BITS
) (
    input  logic [ACC_BITS-1:0]  i_acc,
    input  logic [LIMB_BITS-1:0] i_limb,
    input  logic [DAT_BITS-1:0]  i_b,
    input  logic [IDX_BITS-1:0]  i_idx,
    output logic [ACC_BITS-1:0]  o_acc
);

    localparam int unsigned PROD_BITS = LIMB_BITS + DAT_BITS;

    logic [PROD_BITS-1:0] w_prod;
    logic [ACC_BITS-1:0]  w_prod_sh;

    // Partial product shifted to its limb weight, then accumulated.
    always_comb begin
        w_prod    = PROD_BITS'(i_limb) * PROD_BITS'(i_b);
        w_prod_sh = ACC_BITS'(w_prod) << (32'(i_idx) * LIMB_BITS);
        o_acc     = i_acc + w_prod_sh;
    end

endmodule

// File: rtl/serial_mult_responder.sv
// Limb-serial full-width multiplier on a request/response stream pair.
// Accepts {b, a}, returns a*b (unreduced) NUM_LIMB cycles after accept.
module serial_mult_responder
    import mult_pkg::*;
#(
    parameter int unsigned DAT_BITS  = 381,
    parameter int unsigned LIMB_BITS = 64,
    parameter int unsigned CTL_BITS  = 8,
    localparam int unsigned NUM_LIMB = num_limb(DAT_BITS, LIMB_BITS),
    localparam int unsigned IDX_BITS = cnt_bits(NUM_LIMB),
    localparam int unsigned ACC_BITS = 2 * DAT_BITS + LIMB_BITS
) (
    input logic            i_clk,
    input logic            i_rst_n,
    if_axi_stream.sink     i_mul_if,
    if_axi_stream.source   o_mul_if
);

    localparam int unsigned PAD_BITS = NUM_LIMB * LIMB_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_LIMB - 1);

    mult_state_t           r_state;
    logic [DAT_BITS-1:0]   r_a;
    logic [DAT_BITS-1:0]   r_b;
    logic [CTL_BITS-1:0]   r_ctl;
    logic [ACC_BITS-1:0]   r_acc;
    logic [IDX_BITS-1:0]   r_cnt;

    logic [PAD_BITS-1:0]   w_a_pad;
    logic [LIMB_BITS-1:0]  w_limb;
    logic [ACC_BITS-1:0]   w_acc_next;
    logic                  w_accept;
    logic                  w_unused;

    // Request ready depends only on state and downstream ready, never on request valid.
    assign i_mul_if.rdy = (r_state == IDLE) || ((r_state == OUT) && o_mul_if.rdy);
    assign w_accept     = i_mul_if.val && i_mul_if.rdy;

    assign o_mul_if.err = 1'b0;
    assign o_mul_if.mod = '0;

    // Every request is a single complete beat, so request framing is ignored.
    assign w_unused = ^{i_mul_if.sop, i_mul_if.eop, i_mul_if.err, i_mul_if.mod};

    // Select the current limb of a, zero-padding the top limb above DAT_BITS.
    always_comb begin
        w_a_pad                = '0;
        w_a_pad[DAT_BITS-1:0]  = r_a;
        w_limb                 = LIMB_BITS'(w_a_pad >> (32'(r_cnt) * LIMB_BITS));
    end

    limb_mac #(
        .DAT_BITS  (DAT_BITS),
        .LIMB_BITS (LIMB_BITS)
    ) u_limb_mac (
        .i_acc  (r_acc),
        .i_limb (w_limb),
        .i_b    (r_b),
        .i_idx  (r_cnt),
        .o_acc  (w_acc_next)
    );

    // FSM with registered response; an accept in IDLE or OUT always restarts MUL.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_ctl        <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            o_mul_if.val <= 1'b0;
            o_mul_if.sop <= 1'b0;
            o_mul_if.eop <= 1'b0;
            o_mul_if.dat <= '0;
            o_mul_if.ctl <= '0;
        end else begin
            unique case (r_state)
                IDLE: ;
                MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        // Product of two DAT_BITS operands fits exactly in 2*DAT_BITS.
                        o_mul_if.dat <= w_acc_next[2*DAT_BITS-1:0];
                        o_mul_if.ctl <= r_ctl;
                        o_mul_if.val <= 1'b1;
                        o_mul_if.sop <= 1'b1;
                        o_mul_if.eop <= 1'b1;
                        r_state      <= OUT;
                    end
                end
                OUT: begin
                    if (o_mul_if.rdy) begin
                        o_mul_if.val <= 1'b0;
                        o_mul_if.sop <= 1'b0;
                        o_mul_if.eop <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_accept) begin
                r_a     <= i_mul_if.dat[0+:DAT_BITS];
                r_b     <= i_mul_if.dat[DAT_BITS+:DAT_BITS];
                r_ctl   <= i_mul_if.ctl;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= MUL;
            end
        end
    end

endmodule

// File: tb/tb_serial_mult_responder.sv
// Directed bench for serial_mult_responder at default parameters.
module tb_serial_mult_responder;

    localparam int DB = 381;
    localparam int LB = 64;
    localparam int CB = 8;
    localparam int PB = 2 * DB;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    if_axi_stream #(.DAT_BITS(PB), .CTL_BITS(CB)) req_if ();
    if_axi_stream #(.DAT_BITS(PB), .CTL_BITS(CB)) resp_if ();

    serial_mult_responder #(
        .DAT_BITS  (DB),
        .LIMB_BITS (LB),
        .CTL_BITS  (CB)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_mul_if (req_if),
        .o_mul_if (resp_if)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one request and hold it until it is accepted (bounded).
    task automatic send(input logic [DB-1:0] a, input logic [DB-1:0] b,
                        input logic [CB-1:0] c, output bit ok);
        int k;
        bit r;
        req_if.dat = {b, a};
        req_if.ctl = c;
        req_if.val = 1'b1;
        k = 0;
        r = 1'b0;
        while (!r && k < 50) begin
            r = req_if.rdy;
            tick();
            k++;
        end
        req_if.val = 1'b0;
        ok = r;
    endtask

    // Count cycles until the response is valid (bounded).
    task automatic wait_val(output int n);
        n = 0;
        while (!resp_if.val && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        resp_if.rdy = 1'b1;
        #2;
        i_rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (resp_if.val !== 1'b0) begin
            n_fail++; $display("FAIL reset_val: got %b exp 0", resp_if.val);
        end
        n_tests++;
        if (resp_if.sop !== 1'b0 || resp_if.eop !== 1'b0) begin
            n_fail++; $display("FAIL reset_sop_eop: got %b%b exp 00", resp_if.sop, resp_if.eop);
        end
        n_tests++;
        if (resp_if.dat !== '0) begin
            n_fail++; $display("FAIL reset_dat: got %h exp 0", resp_if.dat);
        end
        n_tests++;
        if (resp_if.ctl !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctl: got %h exp 00", resp_if.ctl);
        end
        i_rst_n = 1'b1;
        tick();
        n_tests++;
        if (req_if.rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_rdy: got %b exp 1", req_if.rdy);
        end
    endtask

    task automatic test_single();
        bit ok;
        int n;
        resp_if.rdy = 1'b1;
        send(381'd3, 381'd5, 8'h2A, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_accept: got 0 exp 1"); end
        wait_val(n);
        n_tests++;
        if (n != 6) begin n_fail++; $display("FAIL single_latency: got %0d exp 6", n); end
        n_tests++;
        if (resp_if.dat !== 762'd15) begin
            n_fail++; $display("FAIL single_dat: got %h exp f", resp_if.dat);
        end
        n_tests++;
        if (resp_if.ctl !== 8'h2A) begin
            n_fail++; $display("FAIL single_ctl: got %h exp 2a", resp_if.ctl);
        end
        n_tests++;
        if (resp_if.sop !== 1'b1 || resp_if.eop !== 1'b1) begin
            n_fail++; $display("FAIL single_sop_eop: got %b%b exp 11", resp_if.sop, resp_if.eop);
        end
        n_tests++;
        if (resp_if.err !== 1'b0 || resp_if.mod !== '0) begin
            n_fail++; $display("FAIL single_err_mod: got %b/%h exp 0/0", resp_if.err, resp_if.mod);
        end
        tick();
        n_tests++;
        if (resp_if.val !== 1'b0) begin
            n_fail++; $display("FAIL single_val_drop: got %b exp 0", resp_if.val);
        end
    endtask

    task automatic test_max();
        bit ok;
        int n;
        logic [DB-1:0] a;
        logic [PB-1:0] e;
        a = '1;
        e = '0;
        e = e - (PB'(1) << 382) + PB'(1);
        resp_if.rdy = 1'b1;
        send(a, a, 8'h5C, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL max_accept: got 0 exp 1"); end
        wait_val(n);
        n_tests++;
        if (n != 6) begin n_fail++; $display("FAIL max_latency: got %0d exp 6", n); end
        n_tests++;
        if (resp_if.dat !== e) begin
            n_fail++; $display("FAIL max_dat: got %h exp %h", resp_if.dat, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] qa [10];
        logic [DB-1:0] qb [10];
        logic [PB-1:0] qe [10];
        logic [383:0]  t;
        int sent, got, cyc, last;
        bit acc;
        for (int i = 0; i < 10; i++) begin
            t = '0;
            for (int w = 0; w < 12; w++) t = {t[351:0], 32'($urandom)};
            qa[i] = t[DB-1:0];
            for (int w = 0; w < 12; w++) t = {t[351:0], 32'($urandom)};
            qb[i] = t[DB-1:0];
            qe[i] = PB'(qa[i]) * PB'(qb[i]);
        end
        resp_if.rdy = 1'b1;
        sent = 0; got = 0; cyc = 0; last = 0;
        req_if.dat = {qb[0], qa[0]};
        req_if.ctl = 8'(0);
        req_if.val = 1'b1;
        while (got < 10 && cyc < 200) begin
            acc = req_if.val && req_if.rdy;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 10) begin
                    req_if.dat = {qb[sent], qa[sent]};
                    req_if.ctl = 8'(sent);
                end else begin
                    req_if.val = 1'b0;
                end
            end
            if (resp_if.val) begin
                n_tests++;
                if (resp_if.dat !== qe[got]) begin
                    n_fail++;
                    $display("FAIL b2b_dat[%0d]: got %h exp %h", got, resp_if.dat, qe[got]);
                end
                n_tests++;
                if (resp_if.ctl !== 8'(got)) begin
                    n_fail++; $display("FAIL b2b_ctl[%0d]: got %h exp %h", got, resp_if.ctl,
                                       8'(got));
                end
                if (got > 0) begin
                    n_tests++;
                    if (cyc - last != 7) begin
                        n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d exp 7", got,
                                           cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
        end
        req_if.val = 1'b0;
        n_tests++;
        if (got != 10) begin n_fail++; $display("FAIL b2b_count: got %0d exp 10", got); end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        int n, hs;
        resp_if.rdy = 1'b0;
        send(381'hFFFF, 381'h10001, 8'h11, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL bp_accept: got 0 exp 1"); end
        wait_val(n);
        n_tests++;
        if (n != 6) begin n_fail++; $display("FAIL bp_latency: got %0d exp 6", n); end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if (resp_if.val !== 1'b1) begin
                n_fail++; $display("FAIL bp_val[%0d]: got %b exp 1", i, resp_if.val);
            end
            n_tests++;
            if (resp_if.dat !== 762'hFFFFFFFF) begin
                n_fail++; $display("FAIL bp_dat[%0d]: got %h exp ffffffff", i, resp_if.dat);
            end
            n_tests++;
            if (req_if.rdy !== 1'b0) begin
                n_fail++; $display("FAIL bp_req_rdy[%0d]: got %b exp 0", i, req_if.rdy);
            end
        end
        resp_if.rdy = 1'b1;
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_if.val && resp_if.rdy) hs++;
            tick();
        end
        n_tests++;
        if (hs != 1) begin n_fail++; $display("FAIL bp_handshakes: got %0d exp 1", hs); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n, seen;
        resp_if.rdy = 1'b1;
        send(381'd5, 381'd9, 8'h33, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rmid_accept: got 0 exp 1"); end
        repeat (3) tick();
        i_rst_n = 1'b0;
        #1;
        n_tests++;
        if (resp_if.val !== 1'b0) begin
            n_fail++; $display("FAIL rmid_val: got %b exp 0", resp_if.val);
        end
        n_tests++;
        if (resp_if.dat !== '0) begin
            n_fail++; $display("FAIL rmid_dat_async: got %h exp 0", resp_if.dat);
        end
        n_tests++;
        if (req_if.rdy !== 1'b1) begin
            n_fail++; $display("FAIL rmid_req_rdy: got %b exp 1", req_if.rdy);
        end
        repeat (2) tick();
        i_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (resp_if.val) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL rmid_no_resp: got %0d exp 0", seen); end
        send(381'd7, 381'd6, 8'h07, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rmid_accept2: got 0 exp 1"); end
        wait_val(n);
        n_tests++;
        if (n != 6) begin n_fail++; $display("FAIL rmid_latency: got %0d exp 6", n); end
        n_tests++;
        if (resp_if.dat !== 762'd42) begin
            n_fail++; $display("FAIL rmid_dat: got %h exp 2a", resp_if.dat);
        end
        n_tests++;
        if (resp_if.ctl !== 8'h07) begin
            n_fail++; $display("FAIL rmid_ctl: got %h exp 07", resp_if.ctl);
        end
        tick();
    endtask

    task automatic test_zero_ctl();
        bit ok;
        int n;
        logic [DB-1:0] b;
        b = 381'(1) << 380;
        resp_if.rdy = 1'b1;
        send('0, b, 8'hFF, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL zero_accept: got 0 exp 1"); end
        wait_val(n);
        n_tests++;
        if (n != 6) begin n_fail++; $display("FAIL zero_latency: got %0d exp 6", n); end
        n_tests++;
        if (resp_if.dat !== '0) begin
            n_fail++; $display("FAIL zero_dat: got %h exp 0", resp_if.dat);
        end
        n_tests++;
        if (resp_if.ctl !== 8'hFF) begin
            n_fail++; $display("FAIL zero_ctl: got %h exp ff", resp_if.ctl);
        end
        tick();
    endtask

    initial begin
        req_if.val  = 1'b0;
        req_if.sop  = 1'b1;
        req_if.eop  = 1'b1;
        req_if.err  = 1'b0;
        req_if.mod  = '0;
        req_if.dat  = '0;
        req_if.ctl  = '0;
        resp_if.rdy = 1'b1;
        test_reset();
        test_single();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_zero_ctl();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
